video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Generates raster timing for the HDMI output path: pixel coordinates, the video data enable, and sync/control bits.
- Sits directly upstream of the three per-channel TMDS encoders. Its de output drives their VDE input; cd drives the blue-channel CD input ({vsync,hsync}); cd of the other channels is tied to 0.
- Also issues an early fetch strobe so the oscilloscope pixel source has LEAD cycles to produce RGB data aligned with de.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active low)
- VS_POL, 0, vsync asserted level (0 = active low)
- LEAD, 2, cycles fetch precedes de (legal range 1..8)
- CNT_W, 11, width of the coordinate counters

Ports:
- clk, input, 1, pixel clock
- rst, input, 1, synchronous reset, active-high
- ce, input, 1, pixel clock enable; all state holds when 0
- de, output, 1, video data enable (to encoder VDE)
- hsync, output, 1, horizontal sync at HS_POL polarity
- vsync, output, 1, vertical sync at VS_POL polarity
- cd, output, 2, {vsync,hsync} (to encoder CD)
- x, output, CNT_W, horizontal position of current output cycle
- y, output, CNT_W, vertical position of current output cycle
- frame_start, output, 1, pulse at position (0,0)
- line_start, output, 1, pulse at x==0 on every line
- fetch, output, 1, asserted LEAD ce-cycles before each de-high pixel
- fetch_x, output, CNT_W, x of the pixel being requested
- fetch_y, output, CNT_W, y of the pixel being requested

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Raster order per line: active, front porch, sync, back porch. Frames follow the same order in lines.
- Internal counters hcnt (0..H_TOTAL-1) and vcnt (0..V_TOTAL-1) advance only when ce=1.
  - hcnt wraps to 0 after H_TOTAL-1.
  - vcnt increments only when hcnt wraps, and itself wraps to 0 after V_TOTAL-1.
- All outputs are registered and mutually aligned. x=hcnt and y=vcnt for the cycle shown.
- de = (x<H_ACTIVE) && (y<V_ACTIVE).
- hsync is asserted when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
- vsync is asserted when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- Asserted level follows HS_POL/VS_POL. cd = {vsync,hsync} as driven on the pins (polarity already applied).
- frame_start = (x==0 && y==0). line_start = (x==0).
- fetch leads de:
  - fetch, fetch_x, fetch_y equal the de/x/y values that will appear LEAD ce-cycles later.
  - They wrap correctly across line and frame boundaries (e.g. LEAD=2: fetch at x=H_TOTAL-2, y=V_TOTAL-1 requests (0,0)).
  - Implement with a second counter pair preset LEAD ahead; no output delay line.
- Reset, when rst=1 on a rising edge:
  - hcnt=vcnt=0.
  - de=0, frame_start=0, line_start=0, hsync/vsync inactive, cd matches.
  - x=y=0.
  - fetch=0, fetch_x=LEAD, fetch_y=0.
  - rst has priority over ce.
- Latency from reset release:
  - On the first edge with rst=0 and ce=1, outputs show position (0,0): de=1, frame_start=1, line_start=1.
  - fetch is not asserted for pixels 0..LEAD-1 of the first frame after reset. The first fetch pulse requests (LEAD,0), not (0,0).
- ce=0 holds every output at its current value. No pulse is stretched or re-emitted on ce re-assertion; each pulse spans exactly one ce=1 cycle.
- Reset mid-frame restarts at (0,0) on the next enabled cycle. Partial lines and frames are not completed.
- Widths: CNT_W must hold H_TOTAL-1 and V_TOTAL-1. Comparisons are unsigned with no truncation.

Test Plan:
- Reset hold 5 cycles, then ce=1 constant -> during reset de=0, hsync=vsync=1, cd=2'b11. First enabled cycle: x=0, y=0, de=1, frame_start=1.
- Run one line from (0,0), ce=1 -> de high exactly 640 cycles (x=0..639), hsync=0 for x=656..751, line_start every 800 cycles, y=1 at cycle 800.
- Run 2 full frames -> vsync=0 exactly on lines 490–491 (1600 cycles), frame_start period 420000 cycles, de high 307200 cycles per frame, y wraps 524->0.
- ce toggling 1-0-0-1 through an hsync edge and a frame wrap -> outputs frozen during ce=0, sequence identical to ce=1 run after removing stalls, no duplicated frame_start.
- LEAD=2: compare fetch/fetch_x/fetch_y against de/x/y delayed 2 cycles over a full frame -> exact match. At x=798, y=524, fetch requests (0,0) with fetch=1.
- Assert rst for 1 cycle at x=300, y=200 -> next cycle reset values, then restart at (0,0) with frame_start=1.

Source files
------------

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator for the HDMI output path. A counter pair (hcnt,
// vcnt) walks the raster: active, front porch, sync, back porch, per line
// and per frame. Every output is decoded from the counters and registered,
// so all outputs line up on the same cycle.
//
// A second counter pair runs LEAD pixels ahead of the main pair. The fetch
// outputs are decoded from it, so the pixel source gets its request LEAD
// enabled cycles before the matching de-high pixel.
//
// Ports
//   clk         : pixel clock
//   rst         : synchronous reset, active high, has priority over ce
//   ce          : pixel clock enable; all state holds while low
//   de          : video data enable (encoder VDE)
//   hsync       : horizontal sync, asserted at HS_POL
//   vsync       : vertical sync, asserted at VS_POL
//   cd          : {vsync, hsync} as driven on the pins (encoder CD)
//   x, y        : position shown on the current output cycle
//   frame_start : one-cycle pulse at position (0,0)
//   line_start  : one-cycle pulse at x == 0
//   fetch       : de value that appears LEAD enabled cycles later
//   fetch_x/y   : position that appears LEAD enabled cycles later
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int LEAD     = 2,
    parameter int CNT_W    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [1:0]       cd,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start,
    output logic             line_start,
    output logic             fetch,
    output logic [CNT_W-1:0] fetch_x,
    output logic [CNT_W-1:0] fetch_y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] LEAD_C   = CNT_W'(LEAD);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic             HS_ON    = (HS_POL != 0);
    localparam logic             VS_ON    = (VS_POL != 0);

    // Main raster counters: the position the next enabled cycle will show.
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    // Fetch counters: always LEAD pixels ahead of the main counters.
    logic [CNT_W-1:0] r_fhcnt;
    logic [CNT_W-1:0] r_fvcnt;

    logic             r_de;
    logic             r_hsync;
    logic             r_vsync;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_frameStart;
    logic             r_lineStart;
    logic             r_fetch;
    logic [CNT_W-1:0] r_fetchX;
    logic [CNT_W-1:0] r_fetchY;

    logic [CNT_W-1:0] w_hcntNext;
    logic [CNT_W-1:0] w_vcntNext;
    logic [CNT_W-1:0] w_fhcntNext;
    logic [CNT_W-1:0] w_fvcntNext;
    logic             w_de;
    logic             w_hsync;
    logic             w_vsync;
    logic             w_fetch;

    // Raster advance for both counter pairs: x wraps at the end of a line,
    // and only then does y step, wrapping at the end of the frame.
    always_comb begin
        w_hcntNext  = r_hcnt + ONE;
        w_vcntNext  = r_vcnt;
        w_fhcntNext = r_fhcnt + ONE;
        w_fvcntNext = r_fvcnt;
        if (r_hcnt == H_LAST) begin
            w_hcntNext = '0;
            w_vcntNext = (r_vcnt == V_LAST) ? '0 : r_vcnt + ONE;
        end
        if (r_fhcnt == H_LAST) begin
            w_fhcntNext = '0;
            w_fvcntNext = (r_fvcnt == V_LAST) ? '0 : r_fvcnt + ONE;
        end
    end

    // Decode the visible region and sync windows from the counters. The
    // sync polarity is applied here so the registered outputs are the pin
    // levels. hsync runs on blanking lines too.
    always_comb begin
        w_de    = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
        w_fetch = (r_fhcnt < H_ACT_C) && (r_fvcnt < V_ACT_C);
        w_hsync = ((r_hcnt >= HS_START) && (r_hcnt < HS_END)) ? HS_ON : ~HS_ON;
        w_vsync = ((r_vcnt >= VS_START) && (r_vcnt < VS_END)) ? VS_ON : ~VS_ON;
    end

    // Registered outputs and counters. Reset parks the main counters at
    // (0,0) with outputs idle, so the first enabled cycle shows pixel (0,0).
    // The fetch pair is preset LEAD ahead, which makes the first fetch
    // request pixel (LEAD,0). With ce low, nothing moves, so no pulse is
    // repeated when ce comes back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_fhcnt      <= LEAD_C;
            r_fvcnt      <= '0;
            r_de         <= 1'b0;
            r_hsync      <= ~HS_ON;
            r_vsync      <= ~VS_ON;
            r_x          <= '0;
            r_y          <= '0;
            r_frameStart <= 1'b0;
            r_lineStart  <= 1'b0;
            r_fetch      <= 1'b0;
            r_fetchX     <= LEAD_C;
            r_fetchY     <= '0;
        end else if (ce) begin
            r_hcnt       <= w_hcntNext;
            r_vcnt       <= w_vcntNext;
            r_fhcnt      <= w_fhcntNext;
            r_fvcnt      <= w_fvcntNext;
            r_de         <= w_de;
            r_hsync      <= w_hsync;
            r_vsync      <= w_vsync;
            r_x          <= r_hcnt;
            r_y          <= r_vcnt;
            r_frameStart <= (r_hcnt == '0) && (r_vcnt == '0);
            r_lineStart  <= (r_hcnt == '0);
            r_fetch      <= w_fetch;
            r_fetchX     <= r_fhcnt;
            r_fetchY     <= r_fvcnt;
        end
    end

    assign de          = r_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign cd          = {r_vsync, r_hsync};
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_frameStart;
    assign line_start  = r_lineStart;
    assign fetch       = r_fetch;
    assign fetch_x     = r_fetchX;
    assign fetch_y     = r_fetchY;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Two instances: A uses the default 640x480 timing, B uses a tiny raster
// (15 x 8, active-high hsync) so whole frames and frame wraps fit in a
// short run. A small raster model tracks the position each instance should
// show, and hand-computed totals and positions are checked alongside it.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        bit hpol, vpol;
        int lead;
    } geo_t;

    typedef struct {
        logic        de, hs, vs, fs, ls, f;
        logic [1:0]  cd;
        logic [10:0] x, y, fx, fy;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    logic        deA, hsA, vsA, fsA, lsA, fA;
    logic [1:0]  cdA;
    logic [10:0] xA, yA, fxA, fyA;
    logic        deB, hsB, vsB, fsB, lsB, fB;
    logic [1:0]  cdB;
    logic [10:0] xB, yB, fxB, fyB;

    int checks = 0;
    int fails  = 0;

    geo_t g[2];
    int   nextH[2];
    int   nextV[2];
    int   shownH[2];
    int   shownV[2];
    bit   valid[2];

    logic [22:0] fq[$];

    always #5 clk = ~clk;

    video_timing_gen dutA (
        .clk(clk), .rst(rst), .ce(ce),
        .de(deA), .hsync(hsA), .vsync(vsA), .cd(cdA),
        .x(xA), .y(yA), .frame_start(fsA), .line_start(lsA),
        .fetch(fA), .fetch_x(fxA), .fetch_y(fyA)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(0), .LEAD(2), .CNT_W(11)
    ) dutB (
        .clk(clk), .rst(rst), .ce(ce),
        .de(deB), .hsync(hsB), .vsync(vsB), .cd(cdB),
        .x(xB), .y(yB), .frame_start(fsB), .line_start(lsB),
        .fetch(fB), .fetch_x(fxB), .fetch_y(fyB)
    );

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic obs_t getObsA();
        obs_t o;
        o.de = deA; o.hs = hsA; o.vs = vsA; o.fs = fsA; o.ls = lsA; o.f = fA;
        o.cd = cdA; o.x = xA; o.y = yA; o.fx = fxA; o.fy = fyA;
        return o;
    endfunction

    function automatic obs_t getObsB();
        obs_t o;
        o.de = deB; o.hs = hsB; o.vs = vsB; o.fs = fsB; o.ls = lsB; o.f = fB;
        o.cd = cdB; o.x = xB; o.y = yB; o.fx = fxB; o.fy = fyB;
        return o;
    endfunction

    // Expected outputs for one instance, from its raster geometry and the
    // position the model says it is showing.
    task automatic checkDut(input int d, input string nm, input obs_t o);
        geo_t gg;
        int htot, vtot, ex, ey, efx, efy;
        logic eDe, eHs, eVs, eFs, eLs, eF;
        gg   = g[d];
        htot = gg.ha + gg.hfp + gg.hs + gg.hbp;
        vtot = gg.va + gg.vfp + gg.vs + gg.vbp;
        if (!valid[d]) begin
            ex = 0; ey = 0; eDe = 1'b0; eFs = 1'b0; eLs = 1'b0;
            eHs = !gg.hpol; eVs = !gg.vpol;
            eF = 1'b0; efx = gg.lead; efy = 0;
        end else begin
            ex  = shownH[d];
            ey  = shownV[d];
            eDe = (ex < gg.ha) && (ey < gg.va);
            eHs = ((ex >= gg.ha + gg.hfp) && (ex < gg.ha + gg.hfp + gg.hs)) ? gg.hpol : !gg.hpol;
            eVs = ((ey >= gg.va + gg.vfp) && (ey < gg.va + gg.vfp + gg.vs)) ? gg.vpol : !gg.vpol;
            eFs = (ex == 0) && (ey == 0);
            eLs = (ex == 0);
            efx = ex + gg.lead;
            efy = ey;
            if (efx >= htot) begin
                efx = efx - htot;
                efy = (efy + 1 >= vtot) ? 0 : efy + 1;
            end
            eF = (efx < gg.ha) && (efy < gg.va);
        end
        checkOutput({nm, " de"}, 32'(o.de), 32'(eDe));
        checkOutput({nm, " hsync"}, 32'(o.hs), 32'(eHs));
        checkOutput({nm, " vsync"}, 32'(o.vs), 32'(eVs));
        checkOutput({nm, " cd"}, 32'(o.cd), 32'({eVs, eHs}));
        checkOutput({nm, " x"}, 32'(o.x), 32'(ex));
        checkOutput({nm, " y"}, 32'(o.y), 32'(ey));
        checkOutput({nm, " frame_start"}, 32'(o.fs), 32'(eFs));
        checkOutput({nm, " line_start"}, 32'(o.ls), 32'(eLs));
        checkOutput({nm, " fetch"}, 32'(o.f), 32'(eF));
        checkOutput({nm, " fetch_x"}, 32'(o.fx), 32'(efx));
        checkOutput({nm, " fetch_y"}, 32'(o.fy), 32'(efy));
    endtask

    // One clock: drive inputs, advance the model on the edge, sample 1 ns
    // later and check both instances. B's fetch outputs are also checked
    // against its own de/x/y LEAD enabled cycles later.
    task automatic applyStimulus(input logic r, input logic c);
        logic [22:0] ent;
        rst = r;
        ce  = c;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            int htot, vtot;
            htot = g[d].ha + g[d].hfp + g[d].hs + g[d].hbp;
            vtot = g[d].va + g[d].vfp + g[d].vs + g[d].vbp;
            if (r) begin
                nextH[d] = 0; nextV[d] = 0; shownH[d] = 0; shownV[d] = 0;
                valid[d] = 1'b0;
            end else if (c) begin
                shownH[d] = nextH[d];
                shownV[d] = nextV[d];
                valid[d]  = 1'b1;
                nextH[d]++;
                if (nextH[d] == htot) begin
                    nextH[d] = 0;
                    nextV[d]++;
                    if (nextV[d] == vtot) nextV[d] = 0;
                end
            end
        end
        #1;
        checkDut(0, "A", getObsA());
        checkDut(1, "B", getObsB());
        if (r) begin
            fq.delete();
        end else if (c) begin
            fq.push_back({fB, fxB, fyB});
            if (fq.size() > g[1].lead) begin
                ent = fq.pop_front();
                checkOutput("B fetch-delay", 32'({deB, xB, yB}), 32'(ent));
            end
        end
    endtask

    initial begin
        int cntDeA, cntHsA, cntLsA;
        int cntDeB, cntVsB, cntHsB, cntFsB;
        bit found;
        logic [3:0] pat;

        g[0] = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33,
                 hpol: 1'b0, vpol: 1'b0, lead: 2};
        g[1] = '{ha: 8, hfp: 2, hs: 3, hbp: 2, va: 4, vfp: 1, vs: 2, vbp: 1,
                 hpol: 1'b1, vpol: 1'b0, lead: 2};
        rst = 1'b1;
        ce  = 1'b1;

        // Reset held 5 cycles.
        repeat (5) applyStimulus(1'b1, 1'b1);
        checkOutput("A rst de", 32'(deA), 32'd0);
        checkOutput("A rst hsync", 32'(hsA), 32'd1);
        checkOutput("A rst vsync", 32'(vsA), 32'd1);
        checkOutput("A rst cd", 32'(cdA), 32'd3);
        checkOutput("A rst fetch_x", 32'(fxA), 32'd2);
        checkOutput("B rst cd", 32'(cdB), 32'd2);

        // First line of A and two frames of B with ce held high.
        cntDeA = 0; cntHsA = 0; cntLsA = 0;
        cntDeB = 0; cntVsB = 0; cntHsB = 0; cntFsB = 0;
        for (int k = 0; k <= 800; k++) begin
            applyStimulus(1'b0, 1'b1);
            if (k == 0) begin
                checkOutput("A first x", 32'(xA), 32'd0);
                checkOutput("A first y", 32'(yA), 32'd0);
                checkOutput("A first de", 32'(deA), 32'd1);
                checkOutput("A first frame_start", 32'(fsA), 32'd1);
                checkOutput("A first fetch_x", 32'(fxA), 32'd2);
            end
            if (k < 800) begin
                if (deA) cntDeA++;
                if (!hsA) cntHsA++;
                if (lsA) cntLsA++;
            end
            if (k == 656) checkOutput("A hsync at 656", 32'(hsA), 32'd0);
            if (k == 655) checkOutput("A hsync at 655", 32'(hsA), 32'd1);
            if (k == 752) checkOutput("A hsync at 752", 32'(hsA), 32'd1);
            if (k < 240) begin
                if (deB) cntDeB++;
                if (!vsB) cntVsB++;
                if (hsB) cntHsB++;
                if (fsB) cntFsB++;
            end
            if (k == 118) begin
                checkOutput("B wrap fetch", 32'(fB), 32'd1);
                checkOutput("B wrap fetch_x", 32'(fxB), 32'd0);
                checkOutput("B wrap fetch_y", 32'(fyB), 32'd0);
            end
            if (k == 119) checkOutput("B y before wrap", 32'(yB), 32'd7);
            if (k == 120) begin
                checkOutput("B y after wrap", 32'(yB), 32'd0);
                checkOutput("B frame_start period", 32'(fsB), 32'd1);
            end
            if (k == 800) begin
                checkOutput("A line2 x", 32'(xA), 32'd0);
                checkOutput("A line2 y", 32'(yA), 32'd1);
                checkOutput("A line2 line_start", 32'(lsA), 32'd1);
            end
        end
        checkOutput("A de count", 32'(cntDeA), 32'd640);
        checkOutput("A hsync count", 32'(cntHsA), 32'd96);
        checkOutput("A line_start count", 32'(cntLsA), 32'd1);
        checkOutput("B de count", 32'(cntDeB), 32'd64);
        checkOutput("B vsync count", 32'(cntVsB), 32'd60);
        checkOutput("B hsync count", 32'(cntHsB), 32'd48);
        checkOutput("B frame_start count", 32'(cntFsB), 32'd2);

        // ce toggling 1-0-0-1: B walks positions 81..280, crossing two
        // frame wraps and several hsync edges in 200 enabled cycles.
        pat = 4'b1001;
        cntFsB = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, pat[i % 4]);
            if (pat[i % 4] && fsB) cntFsB++;
        end
        checkOutput("B stall frame_start count", 32'(cntFsB), 32'd2);

        // Mid-frame reset once B reaches (5,3).
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (xB == 11'd5 && yB == 11'd3) found = 1'b1;
        end
        checkOutput("B reach (5,3)", 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("A midrst de", 32'(deA), 32'd0);
        checkOutput("A midrst x", 32'(xA), 32'd0);
        checkOutput("A midrst fetch", 32'(fA), 32'd0);
        checkOutput("B midrst frame_start", 32'(fsB), 32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("A restart frame_start", 32'(fsA), 32'd1);
        checkOutput("A restart de", 32'(deA), 32'd1);
        checkOutput("B restart x", 32'(xB), 32'd0);
        checkOutput("B restart y", 32'(yB), 32'd0);
        checkOutput("B restart frame_start", 32'(fsB), 32'd1);
        repeat (150) applyStimulus(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
